// File: rtl/neonfox_bus_pkg.sv
// Shared types for the NeonFox load/store bridge: FSM state encoding,
// the registered bus command record and the core byte-enable encoding.
package neonfox_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    DONE     = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  be;
    logic [31:0] addr;
    logic [15:0] wdata;
  } bus_req_t;

  // Core encoding: h_en=l_en=0 means a full word; otherwise the set bits
  // select the byte lanes.
  function automatic logic [1:0] be_encode(input logic h_en, input logic l_en);
    return {h_en | ~l_en, ~h_en | l_en};
  endfunction

endpackage

// File: rtl/bus_port_ctrl.sv
// One bus port of the load/store bridge: holds the command registers,
// runs the req/ack handshake and the wait-state timeout counter, and reports
// completion (done), abort (err) and the read data to hand back.
module bus_port_ctrl #(
  parameter int          AW             = 32,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter logic [15:0] ERR_DATA       = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          fire,
  input  logic          cmd_we,
  input  logic [1:0]    cmd_be,
  input  logic [AW-1:0] cmd_addr,
  input  logic [15:0]   cmd_wdata,
  input  logic          ack,
  input  logic [15:0]   rdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [1:0]    bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [15:0]   bus_wdata,
  output logic          done,
  output logic          err,
  output logic [15:0]   rd_data
);

  logic          req_r;
  logic          we_r;
  logic [1:0]    be_r;
  logic [AW-1:0] addr_r;
  logic [15:0]   wdata_r;
  logic [7:0]    cnt_r;
  logic          hit_s;

  // The counter holds (wait cycles - 1) during a wait cycle, so the abort
  // lands in the TIMEOUT_CYCLES-th wait cycle; zero disables the abort.
  assign hit_s   = (TIMEOUT_CYCLES != 8'd0) && (cnt_r == (TIMEOUT_CYCLES - 8'd1));
  assign done    = req_r & (ack | hit_s);
  assign err     = req_r & ~ack & hit_s;
  assign rd_data = ack ? rdata : ERR_DATA;

  assign bus_req   = req_r;
  assign bus_we    = we_r;
  assign bus_be    = be_r;
  assign bus_addr  = addr_r;
  assign bus_wdata = wdata_r;

  // Command capture, request handshake and wait-cycle counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      be_r    <= 2'b00;
      addr_r  <= {AW{1'b0}};
      wdata_r <= 16'h0000;
      cnt_r   <= 8'd0;
    end else begin
      if (load) begin
        we_r    <= cmd_we;
        be_r    <= cmd_be;
        addr_r  <= cmd_addr;
        wdata_r <= cmd_wdata;
      end
      if (fire) begin
        req_r <= 1'b1;
        cnt_r <= 8'd0;
      end else if (done) begin
        req_r <= 1'b0;
        cnt_r <= 8'd0;
      end else if (req_r) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// NeonFox load/store access stage: one outstanding access at a time on
// separate memory and I/O buses, with pending I/O after a data access,
// wait states and timeout aborts.
// Optional build macro NEONFOX_POSTED_WRITE_EN adds a single-entry posted
// write buffer so a lone write does not stall the pipeline.
module mem_io_bridge
  import neonfox_bus_pkg::*;
#(
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter logic [15:0] ERR_DATA       = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_ren,
  input  logic        data_wren,
  input  logic        IO_ren,
  input  logic        IO_wren,
  input  logic        h_en,
  input  logic        l_en,
  input  logic [31:0] data_address,
  input  logic [15:0] IO_address,
  input  logic [15:0] DIO_out,
  output logic [15:0] DIO_in,
  output logic        data_hazard,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        io_req,
  output logic        io_we,
  output logic [1:0]  io_be,
  output logic [15:0] io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic        io_ack
);

  bridge_state_t state_r, state_nxt_s;
  logic          pend_io_r, pend_io_nxt_s;
  logic [15:0]   dio_in_r, dio_in_nxt_s;
  logic          bus_error_r;
  bus_req_t      mem_cmd_s;
  logic [1:0]    be_s;
  logic          data_any_s, io_any_s, capture_s;
  logic          mem_load_s, mem_fire_s, io_load_s, io_fire_s;
  logic          mem_done_s, mem_err_s, io_done_s, io_err_s;
  logic [15:0]   mem_rd_s, io_rd_s;

  assign be_s       = be_encode(h_en, l_en);
  assign data_any_s = data_ren | data_wren;
  assign io_any_s   = IO_ren | IO_wren;
  assign capture_s  = (state_r == IDLE) & ~data_hazard & (data_any_s | io_any_s);

  // Memory command record; a read in the same cycle as a write wins.
  always_comb begin
    mem_cmd_s.we    = ~data_ren;
    mem_cmd_s.be    = be_s;
    mem_cmd_s.addr  = data_address;
    mem_cmd_s.wdata = DIO_out;
  end

`ifdef NEONFOX_POSTED_WRITE_EN
  logic wb_busy_r, wb_busy_nxt_s;
  logic wb_io_r, wb_io_nxt_s;
  logic post_s, drain_done_s;

  // A lone write (one space, no read) goes to the buffer instead of the FSM.
  assign post_s       = capture_s & (data_any_s ^ io_any_s) &
                        (data_any_s ? ~data_ren : ~IO_ren);
  assign drain_done_s = wb_busy_r & (wb_io_r ? io_done_s : mem_done_s);
  assign data_hazard  = (state_r != IDLE) | (wb_busy_r & (data_any_s | io_any_s));
`else
  assign data_hazard  = (state_r != IDLE);
`endif

  // Next-state, port control and read-data capture.
  always_comb begin
    state_nxt_s   = state_r;
    pend_io_nxt_s = pend_io_r;
    dio_in_nxt_s  = dio_in_r;
    mem_load_s    = 1'b0;
    mem_fire_s    = 1'b0;
    io_load_s     = 1'b0;
    io_fire_s     = 1'b0;
`ifdef NEONFOX_POSTED_WRITE_EN
    wb_io_nxt_s   = wb_io_r;
    if (drain_done_s) begin
      wb_busy_nxt_s = 1'b0;
    end else begin
      wb_busy_nxt_s = wb_busy_r;
    end
`endif
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          mem_load_s = data_any_s;
          io_load_s  = io_any_s;
`ifdef NEONFOX_POSTED_WRITE_EN
          if (post_s) begin
            mem_fire_s    = data_any_s;
            io_fire_s     = io_any_s;
            wb_busy_nxt_s = 1'b1;
            wb_io_nxt_s   = io_any_s;
          end else
`endif
          if (data_any_s) begin
            mem_fire_s    = 1'b1;
            pend_io_nxt_s = io_any_s;
            state_nxt_s   = MEM_WAIT;
          end else begin
            io_fire_s     = 1'b1;
            pend_io_nxt_s = 1'b0;
            state_nxt_s   = IO_WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEM_WAIT: begin
        if (mem_done_s) begin
          if (!mem_we) begin
            dio_in_nxt_s = mem_rd_s;
          end else begin
            dio_in_nxt_s = dio_in_r;
          end
          if (pend_io_r) begin
            io_fire_s     = 1'b1;
            pend_io_nxt_s = 1'b0;
            state_nxt_s   = IO_WAIT;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      IO_WAIT: begin
        if (io_done_s) begin
          if (!io_we) begin
            dio_in_nxt_s = io_rd_s;
          end else begin
            dio_in_nxt_s = dio_in_r;
          end
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IO_WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bridge state, pending-I/O flag, load data and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pend_io_r   <= 1'b0;
      dio_in_r    <= 16'h0000;
      bus_error_r <= 1'b0;
`ifdef NEONFOX_POSTED_WRITE_EN
      wb_busy_r   <= 1'b0;
      wb_io_r     <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      pend_io_r   <= pend_io_nxt_s;
      dio_in_r    <= dio_in_nxt_s;
      bus_error_r <= mem_err_s | io_err_s;
`ifdef NEONFOX_POSTED_WRITE_EN
      wb_busy_r   <= wb_busy_nxt_s;
      wb_io_r     <= wb_io_nxt_s;
`endif
    end
  end

  assign DIO_in    = dio_in_r;
  assign bus_error = bus_error_r;

  bus_port_ctrl #(
    .AW(32), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_DATA(ERR_DATA)
  ) u_mem_port (
    .clk(clk), .rst_n(rst_n), .load(mem_load_s), .fire(mem_fire_s),
    .cmd_we(mem_cmd_s.we), .cmd_be(mem_cmd_s.be), .cmd_addr(mem_cmd_s.addr),
    .cmd_wdata(mem_cmd_s.wdata), .ack(mem_ack), .rdata(mem_rdata),
    .bus_req(mem_req), .bus_we(mem_we), .bus_be(mem_be), .bus_addr(mem_addr),
    .bus_wdata(mem_wdata), .done(mem_done_s), .err(mem_err_s), .rd_data(mem_rd_s)
  );

  bus_port_ctrl #(
    .AW(16), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_DATA(ERR_DATA)
  ) u_io_port (
    .clk(clk), .rst_n(rst_n), .load(io_load_s), .fire(io_fire_s),
    .cmd_we(~IO_ren), .cmd_be(be_s), .cmd_addr(IO_address),
    .cmd_wdata(DIO_out), .ack(io_ack), .rdata(io_rdata),
    .bus_req(io_req), .bus_we(io_we), .bus_be(io_be), .bus_addr(io_addr),
    .bus_wdata(io_wdata), .done(io_done_s), .err(io_err_s), .rd_data(io_rd_s)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge (built with TIMEOUT_CYCLES=4).
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_ren, data_wren, IO_ren, IO_wren, h_en, l_en;
  logic [31:0] data_address;
  logic [15:0] IO_address, DIO_out, DIO_in;
  logic        data_hazard, bus_error;
  logic        mem_req, mem_we, mem_ack;
  logic [1:0]  mem_be;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        io_req, io_we, io_ack;
  logic [1:0]  io_be;
  logic [15:0] io_addr, io_wdata, io_rdata;

  typedef struct packed {
    logic        io;
    logic        we;
    logic [1:0]  be;
    logic [31:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [15:0] exp_rd_q[$];
  int total = 0;
  int bad   = 0;
  int stall_n, span_n, mreq_n, ireq_n, err_n;

`ifdef NEONFOX_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_io_bridge #(.TIMEOUT_CYCLES(8'd4), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .data_ren(data_ren), .data_wren(data_wren),
    .IO_ren(IO_ren), .IO_wren(IO_wren), .h_en(h_en), .l_en(l_en),
    .data_address(data_address), .IO_address(IO_address), .DIO_out(DIO_out),
    .DIO_in(DIO_in), .data_hazard(data_hazard), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_req(io_req), .io_we(io_we), .io_be(io_be), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single capture edge.
  task automatic issue(input logic dr, input logic dw, input logic ir, input logic iw,
                       input logic h, input logic l, input logic [31:0] da,
                       input logic [15:0] ia, input logic [15:0] wd);
    data_ren = dr; data_wren = dw; IO_ren = ir; IO_wren = iw;
    h_en = h; l_en = l; data_address = da; IO_address = ia; DIO_out = wd;
    cyc();
    data_ren = 1'b0; data_wren = 1'b0; IO_ren = 1'b0; IO_wren = 1'b0;
  endtask

  // Bus responder: ack in the lat-th cycle of req (lat=0: never ack).
  task automatic serve(input int mlat, input int ilat,
                       input logic [15:0] mrd, input logic [15:0] ird);
    int mc = 0;
    int ic = 0;
    stall_n = 0; span_n = 0; mreq_n = 0; ireq_n = 0; err_n = 0;
    mem_rdata = mrd; io_rdata = ird;
    while ((data_hazard || mem_req || io_req || bus_error) && span_n < 200) begin
      if (mem_req) begin
        mc++; mreq_n++;
        if (mc == 1) obs_q.push_back({1'b0, mem_we, mem_be, mem_addr, mem_wdata});
      end else mc = 0;
      if (io_req) begin
        ic++; ireq_n++;
        if (ic == 1) obs_q.push_back({1'b1, io_we, io_be, 16'h0000, io_addr, io_wdata});
      end else ic = 0;
      mem_ack = mem_req && (mc == mlat);
      io_ack  = io_req && (ic == ilat);
      if (data_hazard) stall_n++;
      if (bus_error) err_n++;
      span_n++;
      cyc();
    end
    mem_ack = 1'b0; io_ack = 1'b0;
    total++;
    if (span_n >= 200) begin
      bad++;
      $display("FAIL serve_bound: access still active after %0d cycles, required < 200", span_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_ren = 1'b0; data_wren = 1'b0; IO_ren = 1'b0; IO_wren = 1'b0;
    h_en = 1'b0; l_en = 1'b0; data_address = 32'h0; IO_address = 16'h0; DIO_out = 16'h0;
    mem_ack = 1'b0; io_ack = 1'b0; mem_rdata = 16'h0; io_rdata = 16'h0;
    cyc(); cyc();
    total++;
    if ({data_hazard, bus_error, mem_req, mem_we, io_req, io_we, mem_be, io_be} !== 10'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b required 0", {data_hazard, bus_error, mem_req, mem_we, io_req, io_we, mem_be, io_be});
    end
    total++;
    if ({mem_addr, io_addr, mem_wdata, io_wdata} !== 80'h0) begin
      bad++; $display("FAIL reset_addr: got %h required 0", {mem_addr, io_addr, mem_wdata, io_wdata});
    end
    total++;
    if (DIO_in !== 16'h0000) begin
      bad++; $display("FAIL reset_dio: got %h required 0000", DIO_in);
    end
    @(negedge clk); rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_mem_read();
    txn_t o, e;
    exp_q.push_back({1'b0, 1'b0, 2'b11, 32'h1000_0010, 16'h5A5A});
    exp_rd_q.push_back(16'hBEEF);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0010, 16'h0, 16'h5A5A);
    serve(3, 1, 16'hBEEF, 16'h0000);
    total++;
    if (stall_n !== 4) begin bad++; $display("FAIL mem_read_stall: got %0d required 4", stall_n); end
    o = obs_q.pop_front(); e = exp_q.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL mem_read_txn: got %h required %h", o, e); end
    total++;
    if (DIO_in !== exp_rd_q[0]) begin bad++; $display("FAIL mem_read_data: got %h required %h", DIO_in, exp_rd_q[0]); end
    void'(exp_rd_q.pop_front());
  endtask

  task automatic test_io_write();
    txn_t o, e;
    exp_q.push_back({1'b1, 1'b1, 2'b10, 32'h0000_0040, 16'h12AB});
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0040, 16'h12AB);
    serve(1, 1, 16'h0000, 16'h7777);
    total++;
    if (stall_n !== (POSTED ? 0 : 2)) begin
      bad++; $display("FAIL io_write_stall: got %0d required %0d", stall_n, POSTED ? 0 : 2);
    end
    o = obs_q.pop_front(); e = exp_q.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL io_write_txn: got %h required %h", o, e); end
    total++;
    if (DIO_in !== 16'hBEEF) begin bad++; $display("FAIL io_write_dio: got %h required BEEF", DIO_in); end
  endtask

  task automatic test_byte_enables();
    logic [1:0] hl_tab [3];
    logic [1:0] be_tab [3];
    txn_t o, e;
    logic [1:0] hl;
    hl_tab[0] = 2'b01; be_tab[0] = 2'b01;
    hl_tab[1] = 2'b11; be_tab[1] = 2'b11;
    hl_tab[2] = 2'b10; be_tab[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      hl = hl_tab[i];
      exp_q.push_back({1'b0, 1'b1, be_tab[i], 32'h2000_0000 + i, 16'hC000 + 16'(i)});
      issue(1'b0, 1'b1, 1'b0, 1'b0, hl[1], hl[0], 32'h2000_0000 + i, 16'h0, 16'hC000 + 16'(i));
      serve(2, 1, 16'h0000, 16'h0000);
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL be_txn[%0d]: got %h required %h", i, o, e); end
    end
  endtask

  task automatic test_priority();
    txn_t o, e;
    exp_q.push_back({1'b0, 1'b0, 2'b11, 32'h0000_3000, 16'h0101});
    exp_q.push_back({1'b1, 1'b0, 2'b11, 32'h0000_0080, 16'h0101});
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 16'h0080, 16'h0101);
    serve(2, 2, 16'h1111, 16'h2222);
    total++;
    if (stall_n !== 5 || span_n !== 5) begin
      bad++; $display("FAIL prio_stall: got stall=%0d span=%0d required 5/5", stall_n, span_n);
    end
    for (int i = 0; i < 2; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL prio_txn[%0d]: got %h required %h", i, o, e); end
    end
    total++;
    if (DIO_in !== 16'h2222) begin bad++; $display("FAIL prio_data: got %h required 2222", DIO_in); end
  endtask

  task automatic test_rw_same_space();
    txn_t o, e;
    exp_q.push_back({1'b0, 1'b0, 2'b01, 32'h0000_5000, 16'h9999});
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 16'h0, 16'h9999);
    serve(1, 1, 16'h3C3C, 16'h0000);
    o = obs_q.pop_front(); e = exp_q.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL rw_txn: got %h required %h", o, e); end
    total++;
    if (DIO_in !== 16'h3C3C || stall_n !== 2) begin
      bad++; $display("FAIL rw_data: got %h/%0d required 3C3C/2", DIO_in, stall_n);
    end
  endtask

  task automatic test_timeout();
    obs_q.delete();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 16'h0, 16'h0);
    serve(0, 0, 16'h1234, 16'h0000);
    total++;
    if (mreq_n !== 4 || stall_n !== 5) begin
      bad++; $display("FAIL timeout_len: got req=%0d stall=%0d required 4/5", mreq_n, stall_n);
    end
    total++;
    if (err_n !== 1) begin bad++; $display("FAIL timeout_err: got %0d pulses required 1", err_n); end
    total++;
    if (DIO_in !== 16'hFFFF) begin bad++; $display("FAIL timeout_data: got %h required FFFF", DIO_in); end
  endtask

  task automatic test_ack_at_timeout();
    obs_q.delete();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_6100, 16'h0, 16'h0);
    serve(4, 0, 16'hA5A5, 16'h0000);
    total++;
    if (err_n !== 0 || mreq_n !== 4) begin
      bad++; $display("FAIL ack_tmo_err: got err=%0d req=%0d required 0/4", err_n, mreq_n);
    end
    total++;
    if (DIO_in !== 16'hA5A5) begin bad++; $display("FAIL ack_tmo_data: got %h required A5A5", DIO_in); end
  endtask

  task automatic test_stray_ack();
    mem_rdata = 16'hDEAD; io_rdata = 16'hDEAD;
    mem_ack = 1'b1; io_ack = 1'b1;
    cyc(); cyc();
    total++;
    if ({data_hazard, mem_req, io_req, bus_error} !== 4'b0 || DIO_in !== 16'hA5A5) begin
      bad++; $display("FAIL stray_ack: got ctrl=%b dio=%h required 0000/A5A5", {data_hazard, mem_req, io_req, bus_error}, DIO_in);
    end
    mem_ack = 1'b0; io_ack = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    txn_t o, e;
    obs_q.delete();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 16'h0090, 16'h0);
    cyc();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_pre: got mem_req=%b required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, io_req, data_hazard} !== 3'b000) begin
      bad++; $display("FAIL mid_async: got %b required 000", {mem_req, io_req, data_hazard});
    end
    @(negedge clk); rst_n = 1'b1;
    cyc();
    exp_q.push_back({1'b0, 1'b0, 2'b11, 32'h0000_7100, 16'h0000});
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_7100, 16'h0, 16'h0);
    serve(2, 2, 16'h6161, 16'h0000);
    total++;
    if (ireq_n !== 0 || stall_n !== 3 || obs_q.size() !== 1) begin
      bad++; $display("FAIL mid_after: got io=%0d stall=%0d txns=%0d required 0/3/1", ireq_n, stall_n, obs_q.size());
    end
    o = obs_q.pop_front(); e = exp_q.pop_front();
    total++;
    if (o !== e || DIO_in !== 16'h6161) begin
      bad++; $display("FAIL mid_txn: got %h/%h required %h/6161", o, DIO_in, e);
    end
    obs_q.delete();
  endtask

`ifdef NEONFOX_POSTED_WRITE_EN
  task automatic test_posted_write();
    int mc = 0;
    int g  = 0;
    int st = 0;
    bit captured = 1'b0;
    data_wren = 1'b1; data_address = 32'h0000_4000; DIO_out = 16'h4444; h_en = 1'b0; l_en = 1'b0;
    cyc();
    data_wren = 1'b0;
    #1;
    total++;
    if (data_hazard !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      bad++; $display("FAIL posted_nostall: got haz=%b req=%b we=%b required 0/1/1", data_hazard, mem_req, mem_we);
    end
    data_ren = 1'b1; data_address = 32'h0000_4010; mem_rdata = 16'h8181;
    while (g < 100 && (!captured || data_hazard || mem_req)) begin
      if (mem_req) mc++; else mc = 0;
      mem_ack = mem_req && (mc == 2);
      if (!captured && !data_hazard) captured = 1'b1;
      if (data_hazard) st++;
      cyc();
      if (captured) data_ren = 1'b0;
      g++;
    end
    mem_ack = 1'b0;
    total++;
    if (st !== 5 || DIO_in !== 16'h8181) begin
      bad++; $display("FAIL posted_read: got stall=%0d dio=%h required 5/8181", st, DIO_in);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_byte_enables();
    test_priority();
    test_rw_same_space();
    test_timeout();
    test_ack_at_timeout();
    test_stray_ack();
    test_reset_mid();
`ifdef NEONFOX_POSTED_WRITE_EN
    test_posted_write();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Load/store access stage for the NeonFox core. It sits directly downstream of the register file.
- It consumes the register file's data_address, IO_address, read strobes and write data, and runs handshaked transactions on separate memory and I/O buses.
- It returns read data on DIO_in and stalls the pipeline via data_hazard.
- One access is outstanding at a time; wait states and bus timeouts are handled here.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in any wait state before the access is aborted (8-bit counter; 0 disables timeout).
- ERR_DATA, 16'hFFFF, value returned on DIO_in for an aborted read.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- data_ren  in  1  data-space read request
- data_wren  in  1  data-space write request
- IO_ren  in  1  I/O-space read request
- IO_wren  in  1  I/O-space write request
- h_en  in  1  high-byte enable (core encoding)
- l_en  in  1  low-byte enable (core encoding)
- data_address  in  32  data-space address
- IO_address  in  16  I/O-space address
- DIO_out  in  16  store data
- DIO_in  out  16  load data to the register file
- data_hazard  out  1  pipeline stall
- bus_error  out  1  one-cycle pulse on timeout abort
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  2  memory byte enables [1]=high, [0]=low
- mem_addr  out  32  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_ack  in  1  memory acknowledge
- io_req  out  1  I/O request
- io_we  out  1  I/O write enable
- io_be  out  2  I/O byte enables
- io_addr  out  16  I/O address
- io_wdata  out  16  I/O write data
- io_rdata  in  16  I/O read data
- io_ack  in  1  I/O acknowledge

Behaviour:
- Reset (async, rst_n=0): state IDLE; all req/we/be outputs 0; addresses and wdata 0; DIO_in=0; data_hazard=0; bus_error=0; timeout counter=0; pending-IO flag=0.
- Byte enables: be[1]=h_en|~l_en, be[0]=~h_en|l_en. h_en=l_en=0 gives a full word.
- Capture: requests are sampled at the rising edge of cycle T only when data_hazard=0 and state=IDLE.
  - Address, DIO_out and byte enables are registered at that edge.
  - The matching req/we/be/addr/wdata outputs are asserted from T+1.
- Priority: a data-space request beats an I/O request in the same cycle. The I/O request is latched as pending and issued immediately after the data access completes, before IDLE is re-entered.
- Read and write requests in the same space in the same cycle: the read wins and the write is dropped.
- Stall: data_hazard = (state != IDLE), driven combinationally from state. Minimum stall for any access is 1 cycle.
- FSM states:
  - IDLE: on a captured request go to MEM_WAIT or IO_WAIT.
  - MEM_WAIT: hold mem_* stable until mem_ack=1. Then drop mem_req, capture read data, and go to IO_WAIT if I/O is pending, else DONE.
  - IO_WAIT: same as MEM_WAIT on the io_* bus, then go to DONE.
  - DONE: data_hazard=1 for this one cycle, then IDLE.
- Read data:
  - On ack of a read, DIO_in <= rdata.
  - DIO_in holds that value until the next read completes, because the register file consumes it the cycle after the stall releases.
  - Writes never change DIO_in.
- Ack timing: an ack seen while not in the matching wait state is ignored. An ack in the first wait cycle (T+1) is legal.
- Timeout: the counter clears on entry to each wait state and increments each wait cycle.
  - When it reaches TIMEOUT_CYCLES: drop req, set DIO_in=ERR_DATA for reads, pulse bus_error for 1 cycle, proceed as if acked.
  - An ack in the same cycle as the timeout wins; no error is raised.
- Reset mid-access: req drops asynchronously and any pending I/O is discarded.

Optional Feature:
- Macro: NEONFOX_POSTED_WRITE_EN.
- Defined: a single-entry posted write buffer.
  - A write captured while the buffer is empty does not stall (data_hazard stays 0) and drains in the background.
  - A request arriving while the buffer is busy stalls until the drain completes, then is handled normally.
  - A read to the same space and address as the buffered write is stalled until the drain completes.
  - bus_error on a posted write still pulses; no data is affected.
- Undefined: writes stall exactly like reads.

Decomposition:
- Package neonfox_bus_pkg holds:
  - bridge_state_t enum (IDLE, MEM_WAIT, IO_WAIT, DONE);
  - bus_req_t struct (we, be[1:0], addr[31:0], wdata[15:0]);
  - the be-encoding function.
- One natural sub-module: bus_port_ctrl, instantiated twice (memory and I/O). It owns the req/ack handshake and timeout counter for one bus and reports done/err/rdata.

Test Plan:
- Data read, mem_ack 3 cycles after req, mem_rdata=16'hBEEF → data_hazard high for 4 cycles; DIO_in=16'hBEEF when it drops; mem_be=2'b11.
- IO write with h_en=1, l_en=0, IO_address=16'h0040, DIO_out=16'h12AB → io_we=1, io_be=2'b10, io_wdata=16'h12AB; DIO_in unchanged.
- data_ren and IO_ren in the same cycle → mem access completes first, then io access; a single continuous stall.
- No ack, TIMEOUT_CYCLES=4 → req drops after 4 wait cycles; bus_error pulses once; DIO_in=16'hFFFF.
- rst_n low during MEM_WAIT → mem_req=0 and data_hazard=0 immediately; the next request proceeds normally.
- With NEONFOX_POSTED_WRITE_EN, a write then a read to a different address on the next cycle → write has no stall; the read stalls until the drain completes, then returns mem_rdata.
